// File: rtl/bac_io_pkg.sv
// Shared definitions for the BAC-02 I/O peripherals: status bit positions,
// serial FSM state encoding and register offsets.
package bac_io_pkg;

   localparam int ST_RXAVAIL  = 0;
   localparam int ST_TXREADY  = 1;
   localparam int ST_OVERRUN  = 2;
   localparam int ST_FRAMEERR = 3;

   localparam logic [7:0] OFS_DATA = 8'd0;
   localparam logic [7:0] OFS_STAT = 8'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic logic [7:0] status_byte(input logic frame_err, input logic overrun,
                                              input logic tx_ready, input logic rx_avail);
      logic [7:0] st;
      st              = 8'h00;
      st[ST_FRAMEERR] = frame_err;
      st[ST_OVERRUN]  = overrun;
      st[ST_TXREADY]  = tx_ready;
      st[ST_RXAVAIL]  = rx_avail;
      return st;
   endfunction

endpackage

// File: rtl/bac_uart_rxbuf.sv
// Receive buffer for bac_uart_io. BAC_UART_RXFIFO_EN selects a 4-entry FIFO;
// otherwise a single holding register. A pop in the same cycle as a push frees room first.
module bac_uart_rxbuf
   import bac_io_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       empty,
   output logic       full
);

`ifdef BAC_UART_RXFIFO_EN
   logic [7:0] mem_r [4];
   logic [1:0] wp_r;
   logic [1:0] rp_r;
   logic [2:0] count_r;
   logic       do_pop_s;
   logic       do_push_s;

   assign do_pop_s  = pop && (count_r != 3'd0);
   assign do_push_s = push && ((count_r != 3'd4) || do_pop_s);
   assign rdata     = mem_r[rp_r];
   assign empty     = (count_r == 3'd0);
   assign full      = (count_r == 3'd4);

   // Storage array; contents are don't-care while count is zero.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wp_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_r    <= 2'd0;
         rp_r    <= 2'd0;
         count_r <= 3'd0;
      end else begin
         wp_r <= do_push_s ? (wp_r + 2'd1) : wp_r;
         rp_r <= do_pop_s ? (rp_r + 2'd1) : rp_r;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end
`else
   logic [7:0] data_r;
   logic       full_r;

   assign rdata = data_r;
   assign empty = !full_r;
   assign full  = full_r;

   // Single holding register; a simultaneous pop lets the new byte replace the old.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r <= 8'h00;
         full_r <= 1'b0;
      end else if (push && (!full_r || pop)) begin
         data_r <= wdata;
         full_r <= 1'b1;
      end else if (pop) begin
         data_r <= data_r;
         full_r <= 1'b0;
      end else begin
         data_r <= data_r;
         full_r <= full_r;
      end
   end
`endif

endmodule

// File: rtl/bac_uart_io.sv
// I/O-mapped 8N1 UART for the BAC-02 bus: data at BASE, status at BASE+1.
// Optional BAC_UART_RXFIFO_EN deepens the receive buffer (see bac_uart_rxbuf).
module bac_uart_io
   import bac_io_pkg::*;
#(
   parameter logic [7:0] BASE    = 8'h00,
   parameter int         DIVIDER = 217
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_wdata,
   input  logic       io_wr,
   input  logic       io_rd,
   output logic [7:0] io_rdata,
   output logic       io_sel,
   output logic       txd,
   input  logic       rxd
);

   localparam int            CW        = $clog2(DIVIDER);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(DIVIDER - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(DIVIDER / 2 - 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [7:0]    ADDR_DATA = BASE + OFS_DATA;
   localparam logic [7:0]    ADDR_STAT = BASE + OFS_STAT;

   uart_state_e   tx_state_r, rx_state_r;
   logic [CW-1:0] tx_cnt_r, rx_cnt_r;
   logic [2:0]    tx_bit_r, rx_bit_r;
   logic [7:0]    tx_shift_r, rx_shift_r;
   logic          tx_go_r, txd_r;
   logic          rx_sync1_r, rx_sync2_r, rx_prev_r;
   logic          overrun_r, frame_err_r;
   logic          tx_ready_s, wr_data_s, rd_data_s, rd_stat_s, pop_s, push_s;
   logic          rx_tick_s, frame_set_s, buf_empty_s, buf_full_s;
   logic [7:0]    buf_rdata_s, status_s;

   assign txd         = txd_r;
   assign tx_ready_s  = (tx_state_r == IDLE) && !tx_go_r;
   assign wr_data_s   = io_wr && (io_addr == ADDR_DATA);
   assign rd_data_s   = io_rd && (io_addr == ADDR_DATA);
   assign rd_stat_s   = io_rd && (io_addr == ADDR_STAT);
   assign pop_s       = rd_data_s && !buf_empty_s;
   assign rx_tick_s   = (rx_cnt_r == CNT_ZERO);
   assign push_s      = (rx_state_r == STOP) && rx_tick_s && rx_sync2_r;
   assign frame_set_s = (rx_state_r == STOP) && rx_tick_s && !rx_sync2_r;
   assign status_s    = status_byte(frame_err_r, overrun_r, tx_ready_s, !buf_empty_s);
   assign io_sel      = (io_addr == ADDR_DATA) || (io_addr == ADDR_STAT);

   // Combinational read mux: the CPU latches din at the edge ending the IN.
   always_comb begin
      io_rdata = 8'h00;
      if (io_addr == ADDR_DATA) begin
         io_rdata = buf_empty_s ? 8'h00 : buf_rdata_s;
      end else if (io_addr == ADDR_STAT) begin
         io_rdata = status_s;
      end else begin
         io_rdata = 8'h00;
      end
   end

   // Transmitter; the one-cycle go stage makes txd fall one edge after the write.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_r <= IDLE;
         tx_go_r    <= 1'b0;
         tx_cnt_r   <= CNT_ZERO;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         txd_r      <= 1'b1;
      end else begin
         case (tx_state_r)
            IDLE: begin
               if (tx_go_r) begin
                  tx_go_r    <= 1'b0;
                  tx_state_r <= START;
                  tx_cnt_r   <= BIT_LOAD;
                  tx_bit_r   <= 3'd0;
                  txd_r      <= 1'b0;
               end else if (wr_data_s) begin
                  tx_go_r    <= 1'b1;
                  tx_shift_r <= io_wdata;
                  txd_r      <= 1'b1;
               end else begin
                  txd_r <= 1'b1;
               end
            end
            START: begin
               if (tx_cnt_r == CNT_ZERO) begin
                  tx_state_r <= DATA;
                  tx_cnt_r   <= BIT_LOAD;
                  txd_r      <= tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[7:1]};
               end else begin
                  tx_cnt_r <= tx_cnt_r - CNT_ONE;
               end
            end
            DATA: begin
               if (tx_cnt_r == CNT_ZERO) begin
                  tx_cnt_r <= BIT_LOAD;
                  if (tx_bit_r == 3'd7) begin
                     tx_state_r <= STOP;
                     txd_r      <= 1'b1;
                  end else begin
                     tx_bit_r   <= tx_bit_r + 3'd1;
                     txd_r      <= tx_shift_r[0];
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r - CNT_ONE;
               end
            end
            STOP: begin
               if (tx_cnt_r == CNT_ZERO) begin
                  tx_state_r <= IDLE;
                  txd_r      <= 1'b1;
               end else begin
                  tx_cnt_r <= tx_cnt_r - CNT_ONE;
               end
            end
            default: begin
               tx_state_r <= IDLE;
               tx_go_r    <= 1'b0;
               txd_r      <= 1'b1;
            end
         endcase
      end
   end

   // Two-flop synchronizer plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync1_r <= 1'b1;
         rx_sync2_r <= 1'b1;
         rx_prev_r  <= 1'b1;
      end else begin
         rx_sync1_r <= rxd;
         rx_sync2_r <= rx_sync1_r;
         rx_prev_r  <= rx_sync2_r;
      end
   end

   // Receiver: half-bit wait to centre samples, then one sample per bit period.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_r <= IDLE;
         rx_cnt_r   <= CNT_ZERO;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
      end else begin
         case (rx_state_r)
            IDLE: begin
               if (rx_prev_r && !rx_sync2_r) begin
                  rx_state_r <= START;
                  rx_cnt_r   <= HALF_LOAD;
               end else begin
                  rx_state_r <= IDLE;
               end
            end
            START: begin
               if (rx_tick_s) begin
                  rx_state_r <= rx_sync2_r ? IDLE : DATA;
                  rx_cnt_r   <= BIT_LOAD;
                  rx_bit_r   <= 3'd0;
               end else begin
                  rx_cnt_r <= rx_cnt_r - CNT_ONE;
               end
            end
            DATA: begin
               if (rx_tick_s) begin
                  rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
                  rx_cnt_r   <= BIT_LOAD;
                  rx_bit_r   <= rx_bit_r + 3'd1;
                  rx_state_r <= (rx_bit_r == 3'd7) ? STOP : DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r - CNT_ONE;
               end
            end
            STOP: begin
               if (rx_tick_s) begin
                  rx_state_r <= IDLE;
               end else begin
                  rx_cnt_r <= rx_cnt_r - CNT_ONE;
               end
            end
            default: rx_state_r <= IDLE;
         endcase
      end
   end

   // Sticky error flags: a set in the same cycle as a status read wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (push_s && buf_full_s && !pop_s) begin
            overrun_r <= 1'b1;
         end else if (rd_stat_s) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
         if (frame_set_s) begin
            frame_err_r <= 1'b1;
         end else if (rd_stat_s) begin
            frame_err_r <= 1'b0;
         end else begin
            frame_err_r <= frame_err_r;
         end
      end
   end

   bac_uart_rxbuf u_rxbuf (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (rx_shift_r),
      .rdata (buf_rdata_s),
      .empty (buf_empty_s),
      .full  (buf_full_s)
   );

endmodule

// File: tb/tb_bac_uart_io.sv
// Directed bench for bac_uart_io (DIVIDER=4, BASE=8'h10); received bytes are
// tracked in a scoreboard queue and compared when the program reads them.
module tb_bac_uart_io;

   localparam int         DIV  = 4;
   localparam logic [7:0] BASE = 8'h10;
`ifdef BAC_UART_RXFIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] io_addr = 8'h00;
   logic [7:0] io_wdata = 8'h00;
   logic       io_wr = 1'b0;
   logic       io_rd = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] io_rdata;
   logic       io_sel;
   logic       txd;

   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_q [$];

   bac_uart_io #(.BASE(BASE), .DIVIDER(DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .io_rdata (io_rdata),
      .io_sel   (io_sel),
      .txd      (txd),
      .rxd      (rxd)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic peek(input logic [7:0] addr, output logic [7:0] d);
      io_addr = addr;
      io_rd   = 1'b0;
      #1;
      d = io_rdata;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] d);
      io_addr = addr;
      io_rd   = 1'b1;
      #1;
      d = io_rdata;
      step();
      io_rd = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] d);
      io_addr  = addr;
      io_wdata = d;
      io_wr    = 1'b1;
      step();
      io_wr = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input logic expect_it);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      if (expect_it) exp_q.push_back(b);
      for (int i = 0; i < 10; i++) begin
         rxd = fr[i];
         repeat (DIV) step();
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] want;
      logic [9:0] fr;

      // 1. reset state
      repeat (3) step();
      reset = 1'b0;
      peek(8'h11, d);
      chk("reset_status", d, 8'h02);
      chk("reset_sel_stat", {7'd0, io_sel}, 8'h01);
      chk("reset_txd", {7'd0, txd}, 8'h01);
      peek(8'h10, d);
      chk("reset_data_empty", d, 8'h00);
      peek(8'h12, d);
      chk("other_rdata", d, 8'h00);
      chk("other_sel", {7'd0, io_sel}, 8'h00);

      // 2. TX frame of 8'hA5; a write at k+10 must be dropped
      fr = {1'b1, 8'hA5, 1'b0};
      wr(8'h10, 8'hA5);
      for (int c = 1; c <= 48; c++) begin
         step();
         io_wr = 1'b0;
         want = (c <= 40) ? {7'd0, fr[(c - 1) / 4]} : 8'h01;
         chk($sformatf("tx_bit_c%0d", c), {7'd0, txd}, want);
         if (c == 9) begin
            io_addr  = 8'h10;
            io_wdata = 8'h3C;
            io_wr    = 1'b1;
         end else begin
            peek(8'h11, d);
            chk($sformatf("tx_ready_c%0d", c), d, (c >= 41) ? 8'h02 : 8'h00);
         end
      end

      // 3. RX byte with latency check
      send(8'h5A, 1'b1, 1'b1);
      peek(8'h11, d);
      chk("rx_before_latency", d, 8'h02);
      step();
      peek(8'h11, d);
      chk("rx_avail_at_latency", d, 8'h03);
      rd(8'h10, d);
      chk("rx_data", d, exp_q.pop_front());
      peek(8'h11, d);
      chk("rx_after_pop", d, 8'h02);

      // 4. overrun: oldest bytes retained
      for (int i = 0; i <= DEPTH; i++) begin
         send(8'(8'h11 * (i + 1)), 1'b1, (i < DEPTH) ? 1'b1 : 1'b0);
      end
      step();
      peek(8'h11, d);
      chk("ovr_status", d, 8'h07);
      rd(8'h11, d);
      chk("ovr_status_read", d, 8'h07);
      rd(8'h11, d);
      chk("ovr_cleared", d, 8'h03);
      while (exp_q.size() > 0) begin
         rd(8'h10, d);
         chk("ovr_data", d, exp_q.pop_front());
      end
      peek(8'h11, d);
      chk("ovr_drained", d, 8'h02);

      // 5. framing error, then a false start
      send(8'h3C, 1'b0, 1'b0);
      rxd = 1'b1;
      step();
      peek(8'h11, d);
      chk("ferr_status", d, 8'h0A);
      peek(8'h10, d);
      chk("ferr_empty", d, 8'h00);
      rd(8'h11, d);
      rd(8'h11, d);
      chk("ferr_cleared", d, 8'h02);
      rxd = 1'b0;
      step();
      rxd = 1'b1;
      repeat (20) step();
      peek(8'h11, d);
      chk("glitch_status", d, 8'h02);
      peek(8'h10, d);
      chk("glitch_data", d, 8'h00);

      // 6. reset during TX data bit 3 and RX data bit 5
      fr = {1'b1, 8'hC3, 1'b0};
      for (int cyc = 0; cyc < 26; cyc++) begin
         rxd = fr[cyc / 4];
         if (cyc == 7) begin
            io_addr  = 8'h10;
            io_wdata = 8'h96;
            io_wr    = 1'b1;
         end else begin
            io_wr = 1'b0;
         end
         step();
      end
      io_wr = 1'b0;
      peek(8'h11, d);
      chk("mid_busy", d, 8'h00);
      reset = 1'b1;
      rxd   = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_txd", {7'd0, txd}, 8'h01);
      peek(8'h11, d);
      chk("mid_status", d, 8'h02);
      repeat (60) step();
      peek(8'h11, d);
      chk("mid_no_byte_status", d, 8'h02);
      peek(8'h10, d);
      chk("mid_no_byte_data", d, 8'h00);
      chk("mid_txd_idle", {7'd0, txd}, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
